// File: rtl/nn_layer_sequencer.sv
// Sequenced MLP controller: one shared MAC walks every hidden then output neuron,
// streaming weights from a synchronous memory and applying a saturating ReLU.
module nn_layer_sequencer #(
    parameter int N_IN  = 10,
    parameter int N_HID = 5,
    parameter int N_OUT = 3,
    parameter int DW    = 10,
    parameter int ACCW  = 26,
    parameter int FRAC  = 4
) (
    input  logic                 Clock,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DW-1:0]        InVal  [N_IN],
    output logic [6:0]           WAddr,
    input  logic signed [DW-1:0] WData,
    output logic [DW-1:0]        HidVal [N_HID],
    output logic [DW-1:0]        OutVal [N_OUT],
    output logic [1:0]           Class,
    output logic                 Busy,
    output logic                 Done
);

    localparam int KW = $clog2(N_IN);
    localparam int HW = $clog2(N_HID);
    localparam int OW = $clog2(N_OUT);
    localparam int PW = 2 * DW + 1;

    typedef enum logic [3:0] {
        IDLE, LOAD, HID_MAC, HID_DRAIN, HID_WB, OUT_MAC, OUT_DRAIN, OUT_WB, DONE
    } state_e;

    state_e                 state_q;
    logic [DW-1:0]          in_q   [N_IN];
    logic [DW-1:0]          hid_q  [N_HID];
    logic [DW-1:0]          out_q  [N_OUT];
    logic [KW-1:0]          k_q;
    logic [KW-1:0]          tk_q;
    logic [HW-1:0]          n_q;
    logic signed [ACCW-1:0] acc_q;
    logic [6:0]             waddr_q;
    logic [1:0]             class_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   out_layer;
    logic [DW-1:0]          act_sel;
    logic signed [PW-1:0]   w_ext;
    logic signed [PW-1:0]   a_ext;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] shifted;
    logic [DW-1:0]          act_d;
    logic [DW-1:0]          out_new [N_OUT];
    logic [DW-1:0]          best;
    logic [1:0]             class_d;

    // tk_q trails k_q by one cycle: it names the term whose weight is on WData now.
    always_comb begin
        out_layer = (state_q == OUT_MAC) || (state_q == OUT_DRAIN);
        act_sel   = out_layer ? hid_q[tk_q[HW-1:0]] : in_q[tk_q];
        w_ext     = {{(DW+1){WData[DW-1]}}, WData};
        a_ext     = {{(DW+1){1'b0}}, act_sel};
        prod      = w_ext * a_ext;
        acc_d     = acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
        shifted   = acc_q >>> FRAC;
        if (shifted[ACCW-1])
            act_d = '0;
        else if (|shifted[ACCW-2:DW])
            act_d = '1;
        else
            act_d = shifted[DW-1:0];

        // Argmax must see the output being written in the final OUT_WB.
        out_new = out_q;
        if (state_q == OUT_WB)
            out_new[n_q[OW-1:0]] = act_d;
        class_d = '0;
        best    = out_new[0];
        for (int unsigned m = 1; m < N_OUT; m++) begin
            if (out_new[m] > best) begin
                best    = out_new[m];
                class_d = 2'(m);
            end
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            in_q    <= '{default: '0};
            hid_q   <= '{default: '0};
            out_q   <= '{default: '0};
            k_q     <= '0;
            tk_q    <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            waddr_q <= '0;
            class_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tk_q   <= k_q;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    in_q    <= InVal;
                    waddr_q <= '0;
                    k_q     <= '0;
                    n_q     <= '0;
                    state_q <= HID_MAC;
                end
                HID_MAC: begin
                    acc_q <= (k_q == '0) ? '0 : acc_d;
                    if (k_q == KW'(N_IN - 1)) begin
                        state_q <= HID_DRAIN;
                    end else begin
                        k_q     <= k_q + KW'(1);
                        waddr_q <= waddr_q + 7'd1;
                    end
                end
                HID_DRAIN: begin
                    acc_q   <= acc_d;
                    state_q <= HID_WB;
                end
                // Weights are laid out contiguously, so the next neuron starts at WAddr+1.
                HID_WB: begin
                    hid_q[n_q] <= act_d;
                    waddr_q    <= waddr_q + 7'd1;
                    k_q        <= '0;
                    if (n_q == HW'(N_HID - 1)) begin
                        n_q     <= '0;
                        state_q <= OUT_MAC;
                    end else begin
                        n_q     <= n_q + HW'(1);
                        state_q <= HID_MAC;
                    end
                end
                OUT_MAC: begin
                    acc_q <= (k_q == '0) ? '0 : acc_d;
                    if (k_q == KW'(N_HID - 1)) begin
                        state_q <= OUT_DRAIN;
                    end else begin
                        k_q     <= k_q + KW'(1);
                        waddr_q <= waddr_q + 7'd1;
                    end
                end
                OUT_DRAIN: begin
                    acc_q   <= acc_d;
                    state_q <= OUT_WB;
                end
                OUT_WB: begin
                    out_q[n_q[OW-1:0]] <= act_d;
                    k_q                <= '0;
                    if (n_q == HW'(N_OUT - 1)) begin
                        class_q <= class_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        waddr_q <= waddr_q + 7'd1;
                        n_q     <= n_q + HW'(1);
                        state_q <= OUT_MAC;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WAddr  = waddr_q;
    assign HidVal = hid_q;
    assign OutVal = out_q;
    assign Class  = class_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule
